// File: rtl/ram_array_dp.sv
// Simple-dual-port RAM (1W/1R) with a self-clearing sweep after reset or on clr.
// Read latency 1, or 2 when RAM_OUTREG_EN is defined (extra output register stage).
// No backpressure: wr/rd are dropped while busy; dout holds between reads.
module ram_array_dp #(
    parameter int DW       = 4,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int RDW_MODE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] din,
    input  logic          rd,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          busy
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          clr_start;

    logic [DW-1:0] mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;

    logic          waddr_ok, raddr_ok, rd_acc;
    logic [DW-1:0] rd_dat;

    logic [DW-1:0] dout1_q;
    logic          vld1_q;

    assign waddr_ok = 32'(waddr) < DEPTH;
    assign raddr_ok = 32'(raddr) < DEPTH;
    // A clr in a READY cycle turns the whole cycle into the start of a sweep.
    assign rd_acc   = rd && (state_q == READY) && !clr;

    // State and sweep pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Next state, sweep pointer and the single memory write port select
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        busy       = 1'b0;
        clr_start  = 1'b0;
        mem_we     = 1'b0;
        mem_wa     = waddr;
        mem_wd     = din;
        case (state_q)
            CLEAR: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                mem_wa = clr_addr_q;
                mem_wd = '0;
                if (clr) begin
                    clr_addr_d = '0;
                end else if (clr_addr_q == LAST_ADDR) begin
                    state_d    = READY;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            READY: begin
                if (clr) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                    clr_start  = 1'b1;
                end else if (wr && waddr_ok) begin
                    mem_we = 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Storage array; reset wins over any write in the same cycle
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // Read data select: out-of-range reads return zero, same-address bypass in new-data mode
    always_comb begin
        rd_dat = '0;
        if (raddr_ok) begin
            rd_dat = mem_q[raddr];
            if ((RDW_MODE != 0) && mem_we && (mem_wa == raddr)) begin
                rd_dat = din;
            end
        end
    end

    // First read stage: capture data on an accepted read, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            dout1_q <= '0;
            vld1_q  <= 1'b0;
        end else begin
            vld1_q <= rd_acc;
            if (rd_acc) begin
                dout1_q <= rd_dat;
            end
        end
    end

`ifdef RAM_OUTREG_EN
    logic [DW-1:0] dout2_q;
    logic          vld2_q;

    // Output pipeline stage; a new sweep discards any read still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            dout2_q <= '0;
            vld2_q  <= 1'b0;
        end else if (clr_start) begin
            vld2_q <= 1'b0;
        end else begin
            vld2_q <= vld1_q;
            if (vld1_q) begin
                dout2_q <= dout1_q;
            end
        end
    end

    assign dout       = dout2_q;
    assign dout_valid = vld2_q;
`else
    assign dout       = dout1_q;
    assign dout_valid = vld1_q;
`endif

endmodule

// File: tb/tb_ram_array_dp.sv
// Directed bench for ram_array_dp: two instances share stimulus,
// A = 32 entries new-data RDW, B = 20 entries old-data RDW.
// Read latency follows RAM_OUTREG_EN.
module tb_ram_array_dp;

`ifdef RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, clr, wr, rd;
    logic [4:0] waddr, raddr;
    logic [3:0] din;
    logic [3:0] dout_a, dout_b;
    logic       vld_a, vld_b, busy_a, busy_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_array_dp #(.DW(4), .DEPTH(32), .RDW_MODE(1)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .waddr(waddr), .din(din),
        .rd(rd), .raddr(raddr), .dout(dout_a), .dout_valid(vld_a), .busy(busy_a)
    );

    ram_array_dp #(.DW(4), .DEPTH(20), .RDW_MODE(0)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .waddr(waddr), .din(din),
        .rd(rd), .raddr(raddr), .dout(dout_b), .dout_valid(vld_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [3:0] d);
        wr = 1'b1; waddr = a; din = d;
        cycle();
        wr = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [4:0] a,
                           input logic [3:0] ea, input logic [3:0] eb);
        rd = 1'b1; raddr = a;
        cycle();
        rd = 1'b0;
        repeat (LAT - 1) cycle();
        check({tag, " vld_a"}, 32'(vld_a), 32'd1);
        check({tag, " dout_a"}, 32'(dout_a), 32'(ea));
        check({tag, " vld_b"}, 32'(vld_b), 32'd1);
        check({tag, " dout_b"}, 32'(dout_b), 32'(eb));
    endtask

    // Counts busy cycles of each instance over a fixed 40-cycle window.
    task automatic count_busy(output int na, output int nb);
        na = 0; nb = 0;
        for (int i = 0; i < 40; i++) begin
            na += int'(busy_a);
            nb += int'(busy_b);
            cycle();
        end
    endtask

    initial begin
        int na, nb, any_vld;
        rst = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0;
        waddr = '0; raddr = '0; din = '0;

        // 1. reset state, sweep length, all entries zero
        cycle();
        cycle();
        rst = 1'b0;
        check("rst dout_a", 32'(dout_a), 32'd0);
        check("rst vld_a", 32'(vld_a), 32'd0);
        check("rst busy_a", 32'(busy_a), 32'd1);
        check("rst busy_b", 32'(busy_b), 32'd1);
        count_busy(na, nb);
        check("rst busy len a", 32'(na), 32'd32);
        check("rst busy len b", 32'(nb), 32'd20);
        for (int i = 0; i < 32; i++) do_read("init rd", 5'(i), 4'h0, 4'h0);

        // 2. write then read, and hold after the read
        do_write(5'd5, 4'hA);
        do_read("wr5 rd5", 5'd5, 4'hA, 4'hA);
        cycle();
        check("hold vld_a", 32'(vld_a), 32'd0);
        check("hold dout_a", 32'(dout_a), 32'hA);

        // 3. same-address read during write
        do_write(5'd7, 4'h3);
        wr = 1'b1; waddr = 5'd7; din = 4'hC;
        rd = 1'b1; raddr = 5'd7;
        cycle();
        wr = 1'b0; rd = 1'b0;
        repeat (LAT - 1) cycle();
        check("rdw vld_a", 32'(vld_a), 32'd1);
        check("rdw new dout_a", 32'(dout_a), 32'hC);
        check("rdw vld_b", 32'(vld_b), 32'd1);
        check("rdw old dout_b", 32'(dout_b), 32'h3);
        do_read("after rdw", 5'd7, 4'hC, 4'hC);

        // 6. out-of-range on the 20-entry instance, and its last valid entry
        do_write(5'd25, 4'h9);
        do_read("oor rd25", 5'd25, 4'h9, 4'h0);
        do_write(5'd19, 4'h6);
        do_read("edge rd19", 5'd19, 4'h6, 4'h6);

        // 4. fill, clear, accesses during busy are dropped
        for (int i = 0; i < 32; i++) do_write(5'(i), 4'hF);
        do_read("fill rd2", 5'd2, 4'hF, 4'hF);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        na = 0; nb = 0; any_vld = 0;
        for (int i = 0; i < 40; i++) begin
            na += int'(busy_a);
            nb += int'(busy_b);
            any_vld += int'(vld_a) + int'(vld_b);
            wr = (i >= 2 && i < 6);
            rd = wr;
            waddr = 5'd2; raddr = 5'd2; din = 4'h5;
            cycle();
        end
        wr = 1'b0; rd = 1'b0;
        check("clr busy len a", 32'(na), 32'd32);
        check("clr busy len b", 32'(nb), 32'd20);
        check("busy no vld", 32'(any_vld), 32'd0);
        for (int i = 0; i < 32; i++) do_read("post clr rd", 5'(i), 4'h0, 4'h0);

        // 5. reset mid-sweep at clr_addr=10 restarts the full sweep
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        repeat (10) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        count_busy(na, nb);
        check("rst mid clr len a", 32'(na), 32'd32);
        check("rst mid clr len b", 32'(nb), 32'd20);

        // reset in the same cycle as a read cancels the read
        do_write(5'd4, 4'h8);
        rd = 1'b1; raddr = 5'd4; rst = 1'b1;
        cycle();
        rd = 1'b0; rst = 1'b0;
        repeat (LAT - 1) cycle();
        check("rst cancel vld_a", 32'(vld_a), 32'd0);
        check("rst cancel vld_b", 32'(vld_b), 32'd0);
        check("rst cancel dout_a", 32'(dout_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
